bht_update_unit: RTL and testbench
==================================

# bht_update_unit

Resolution-side companion of the local-history branch history table. Accepts resolved conditional branches from execute, buffers them in a small FIFO, reads the addressed BHT entry through its check port, computes the next 2-bit history and 2-bit saturating counter, and writes the entry back through the BHT update port. Also flags mispredictions and keeps a running misprediction count.

## Interface
- INDEX, 5, BHT index width; 2**INDEX entries
- DEPTH, 4, resolution FIFO depth; power of 2, at least 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- res_valid  in  1  resolved branch offered
- res_ready  out  1  FIFO can accept; equals !full
- res_index  in  INDEX  BHT index of the resolved branch
- res_taken  in  1  actual outcome; 1 = taken
- chk  out  1  BHT check strobe
- cindex  out  INDEX  BHT check index
- hist_in  in  2  BHT pc_curr_hist for cindex
- counters_in  in  8  BHT counters for cindex
- pred_in  in  1  BHT predicted_taken_not_taken for cindex
- upd  out  1  BHT update strobe
- windex  out  INDEX  BHT write index
- datain_update  out  10  new entry, {hist[1:0], ctr_NN, ctr_NT, ctr_TN, ctr_TT}
- mispredict  out  1  one-cycle pulse, registered prediction != actual outcome
- mispredict_count  out  32  total mispredictions since reset; wraps
- idle  out  1  FIFO empty and S2 invalid

## Operation
- Entry layout: [9:8] history, [7:6] NN, [5:4] NT, [3:2] TN, [1:0] TT. Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. The BHT resets each entry to {11, 8'h00}.
- Push: an item is pushed when res_valid && res_ready. A push and a pop in the same cycle are legal. When full, res_ready=0 and res_valid is ignored.
- S1 (combinational on FIFO head): when the FIFO is non-empty, drive chk=1 and cindex=head.index, and pop the head that cycle. The pipeline never stalls.
- Forwarding: if S2 is valid and S2.index == head.index, S1 ignores hist_in, counters_in and pred_in. It uses S2's datain_update instead and derives the prediction from that value. This covers the case where the BHT write lands on the same edge.
- S1 → S2 register: index, taken, hist, counters, pred.
- S2 computation:
  - Counter slot: h = hist; the counter lives at bits [7-2h : 6-2h].
  - If taken, increment the counter, saturating at 11. Otherwise decrement it, saturating at 00. The other three counters are unchanged.
  - New history = {hist[0], taken}.
  - Drive upd=1, windex=S2.index, and datain_update = {new_hist, new_counters}.
  - Drive mispredict = (pred != taken), and increment mispredict_count on the same edge.
- Outputs are combinational from S2 and FIFO state. chk, upd and mispredict are 0 whenever the corresponding stage is empty.

## Timing
- Reset values: res_ready=1, chk=0, cindex=0, upd=0, windex=0, datain_update=0, mispredict=0, mispredict_count=0, idle=1.
- Latency with an empty pipeline:
  - Push at edge t.
  - S1 active in cycle t→t+1.
  - upd asserted in cycle t+1→t+2.
  - BHT written at edge t+2.
- Throughput: 1 resolution per cycle.
- Back-to-back resolutions to the same index are correct via forwarding. Three consecutive resolutions to the same index chain correctly.
- Full FIFO with a simultaneous pop: res_ready stays 0 in that cycle. It is derived from registered occupancy, not from the pop.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1 range count.
- mispredict_count wraps from 0xFFFFFFFF to 0.
- Reset mid-operation: FIFO flushed and S2 invalidated on the reset edge. No upd is issued for in-flight items.

## Structure
- Package bht_pkg holds:
  - hist_t (2 bits) and ctr_t (2 bits);
  - the counter encoding constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST;
  - a packed struct for the 10-bit entry;
  - BHT_RESET_ENTRY = {2'b11, 8'h00};
  - the functions ctr_next(ctr, taken) and ctr_pred(ctr).
- One sub-module: bht_res_fifo, parameterised by width and DEPTH, with push/pop/full/empty.
- S1/S2 logic and forwarding live in the top.

## Test plan
- Reset entry at index 3, hist 11, counters 00: push taken → upd with windex=3, datain_update=10'b11_00_00_00_01; mispredict=1; count=1.
- Index 5 with hist 01, counters 8'b00_11_00_00, not taken → datain_update=10'b10_00_10_00_00; mispredict=0.
- Saturation: ST counter with taken leaves 11; SNT counter with not-taken leaves 00.
- Four back-to-back taken pushes to index 7, starting from the reset entry:
  - upd stream histories 11, 11, 11, 11;
  - TT counter 01, 10, 11, 11 (forwarding);
  - mispredict pulses on the first two only.
- Hold the BHT model stalled-free and push DEPTH+2 items with res_valid held high → res_ready drops only when occupancy hits DEPTH; no item is lost or duplicated; ordering is preserved.
- Assert rst with 3 items queued → no upd afterwards, idle=1, mispredict_count=0, res_ready=1 on the next cycle.

Source files
------------

// File: rtl/bht_pkg.sv
`default_nettype none
// ============================================================================
// Package : bht_pkg
// Entry/counter types and update helpers for the local-history BHT.
// Rev     : 1.0
// ============================================================================
package bht_pkg;

    typedef logic [1:0] hist_t;
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef struct packed {
        hist_t hist;
        ctr_t  nn;
        ctr_t  nt;
        ctr_t  tn;
        ctr_t  tt;
    } bht_entry_t;

    localparam bht_entry_t BHT_RESET_ENTRY = {2'b11, 8'h00};

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST)
                res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT)
                res = ctr - 2'd1;
        end
        return res;
    endfunction

    function automatic logic ctr_pred(input ctr_t ctr);
        return ctr[1];
    endfunction

    // History value h selects counter at bits [7-2h:6-2h], i.e. NN for 00 .. TT for 11
    function automatic ctr_t entry_ctr(input bht_entry_t e, input hist_t h);
        ctr_t res;
        case (h)
            2'b00:   res = e.nn;
            2'b01:   res = e.nt;
            2'b10:   res = e.tn;
            default: res = e.tt;
        endcase
        return res;
    endfunction

    function automatic bht_entry_t entry_update(input bht_entry_t e, input logic taken);
        bht_entry_t res;
        res = e;
        case (e.hist)
            2'b00:   res.nn = ctr_next(e.nn, taken);
            2'b01:   res.nt = ctr_next(e.nt, taken);
            2'b10:   res.tn = ctr_next(e.tn, taken);
            default: res.tt = ctr_next(e.tt, taken);
        endcase
        res.hist = {e.hist[0], taken};
        return res;
    endfunction

    function automatic logic entry_pred(input bht_entry_t e);
        return ctr_pred(entry_ctr(e, e.hist));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_res_fifo.sv
`default_nettype none
// ============================================================================
// Module : bht_res_fifo
// Resolution FIFO; pointers wrap modulo DEPTH, occupancy held as 0..DEPTH.
// Rev    : 1.0
// ============================================================================
module bht_res_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bht_update_unit.sv
`default_nettype none
// ============================================================================
// Module : bht_update_unit
// Buffers resolved branches, reads the BHT entry (S1), writes it back (S2).
// Rev    : 1.0
// ============================================================================
module bht_update_unit #(
    parameter int INDEX = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [INDEX-1:0] res_index,
    input  logic             res_taken,
    output logic             chk,
    output logic [INDEX-1:0] cindex,
    input  logic [1:0]       hist_in,
    input  logic [7:0]       counters_in,
    input  logic             pred_in,
    output logic             upd,
    output logic [INDEX-1:0] windex,
    output logic [9:0]       datain_update,
    output logic             mispredict,
    output logic [31:0]      mispredict_count,
    output logic             idle
);

    import bht_pkg::*;

    localparam int c_fifo_w = INDEX + 1;

    logic [c_fifo_w-1:0] w_head;
    logic [INDEX-1:0]    w_head_index;
    logic                w_head_taken;
    logic                w_full;
    logic                w_empty;

    logic                r_s2_valid;
    logic [INDEX-1:0]    r_s2_index;
    logic                r_s2_taken;
    bht_entry_t          r_s2_entry;
    logic                r_s2_pred;
    logic [31:0]         r_mp_count;

    bht_entry_t          w_s2_next;
    logic                w_fwd;
    bht_entry_t          w_s1_entry;
    logic                w_s1_pred;
    logic                w_mispredict;

    bht_res_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid),
        .din   ({res_index, res_taken}),
        .pop   (!w_empty),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head_index = w_head[c_fifo_w-1:1];
    assign w_head_taken = w_head[0];

    assign w_s2_next    = entry_update(r_s2_entry, r_s2_taken);

    // The BHT write of S2 lands on the same edge S1 samples, so bypass the stale read
    assign w_fwd        = r_s2_valid && (r_s2_index == w_head_index);
    assign w_s1_entry   = w_fwd ? w_s2_next : bht_entry_t'({hist_in, counters_in});
    assign w_s1_pred    = w_fwd ? entry_pred(w_s2_next) : pred_in;

    assign w_mispredict = r_s2_valid && (r_s2_pred != r_s2_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_index <= '0;
            r_s2_taken <= 1'b0;
            r_s2_entry <= '0;
            r_s2_pred  <= 1'b0;
            r_mp_count <= '0;
        end else begin
            r_s2_valid <= !w_empty;
            if (!w_empty) begin
                r_s2_index <= w_head_index;
                r_s2_taken <= w_head_taken;
                r_s2_entry <= w_s1_entry;
                r_s2_pred  <= w_s1_pred;
            end
            if (w_mispredict)
                r_mp_count <= r_mp_count + 32'd1;
        end
    end

    assign res_ready        = !w_full;
    assign chk              = !w_empty;
    assign cindex           = w_empty ? '0 : w_head_index;
    assign upd              = r_s2_valid;
    assign windex           = r_s2_valid ? r_s2_index : '0;
    assign datain_update    = r_s2_valid ? w_s2_next : 10'd0;
    assign mispredict       = w_mispredict;
    assign mispredict_count = r_mp_count;
    assign idle             = w_empty && !r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_bht_update_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_bht_update_unit
// Directed self-checking bench with a behavioural BHT behind the check/update ports.
// Rev    : 1.0
// ============================================================================
module tb_bht_update_unit;

    localparam int INDEX = 5;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             res_valid;
    logic             res_ready;
    logic [INDEX-1:0] res_index;
    logic             res_taken;
    logic             chk;
    logic [INDEX-1:0] cindex;
    logic [1:0]       hist_in;
    logic [7:0]       counters_in;
    logic             pred_in;
    logic             upd;
    logic [INDEX-1:0] windex;
    logic [9:0]       datain_update;
    logic             mispredict;
    logic [31:0]      mispredict_count;
    logic             idle;

    int vec;
    int errs;

    bht_update_unit #(.INDEX(INDEX), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_index        (res_index),
        .res_taken        (res_taken),
        .chk              (chk),
        .cindex           (cindex),
        .hist_in          (hist_in),
        .counters_in      (counters_in),
        .pred_in          (pred_in),
        .upd              (upd),
        .windex           (windex),
        .datain_update    (datain_update),
        .mispredict       (mispredict),
        .mispredict_count (mispredict_count),
        .idle             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BHT: reset entries, optional preload, written by upd
    logic [9:0] bht_mem [32];
    logic       pl_en;
    logic [4:0] pl_idx;
    logic [9:0] pl_val;
    logic       pf_en;
    logic       pf_val;
    logic [9:0] cur_entry;
    logic [1:0] cur_slot;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++)
                bht_mem[k] <= 10'h300;
        end else begin
            if (pl_en)
                bht_mem[pl_idx] <= pl_val;
            if (upd)
                bht_mem[windex] <= datain_update;
        end
    end

    assign cur_entry = bht_mem[cindex];
    always_comb begin
        cur_slot = 2'b00;
        case (cur_entry[9:8])
            2'b00:   cur_slot = cur_entry[7:6];
            2'b01:   cur_slot = cur_entry[5:4];
            2'b10:   cur_slot = cur_entry[3:2];
            default: cur_slot = cur_entry[1:0];
        endcase
    end
    assign hist_in     = cur_entry[9:8];
    assign counters_in = cur_entry[7:0];
    assign pred_in     = pf_en ? pf_val : cur_slot[1];

    task automatic preload(input logic [4:0] idx, input logic [9:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    task automatic send_one(input logic [4:0] idx, input logic tk,
                            output logic s1_chk, output logic [4:0] s1_cindex,
                            output logic s2_upd, output logic [4:0] s2_windex,
                            output logic [9:0] s2_data, output logic s2_mp);
        @(negedge clk);
        res_valid = 1'b1;
        res_index = idx;
        res_taken = tk;
        @(negedge clk);
        res_valid = 1'b0;
        s1_chk    = chk;
        s1_cindex = cindex;
        @(negedge clk);
        s2_upd    = upd;
        s2_windex = windex;
        s2_data   = datain_update;
        s2_mp     = mispredict;
    endtask

    task automatic test_reset;
        vec++; if (res_ready !== 1'b1) begin errs++; $display("FAIL reset_res_ready got %b want 1", res_ready); end
        vec++; if (chk !== 1'b0) begin errs++; $display("FAIL reset_chk got %b want 0", chk); end
        vec++; if (cindex !== 5'd0) begin errs++; $display("FAIL reset_cindex got %0d want 0", cindex); end
        vec++; if (upd !== 1'b0) begin errs++; $display("FAIL reset_upd got %b want 0", upd); end
        vec++; if (windex !== 5'd0) begin errs++; $display("FAIL reset_windex got %0d want 0", windex); end
        vec++; if (datain_update !== 10'd0) begin errs++; $display("FAIL reset_datain got %h want 000", datain_update); end
        vec++; if (mispredict !== 1'b0) begin errs++; $display("FAIL reset_mispredict got %b want 0", mispredict); end
        vec++; if (mispredict_count !== 32'd0) begin errs++; $display("FAIL reset_count got %0d want 0", mispredict_count); end
        vec++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle got %b want 1", idle); end
    endtask

    task automatic test_basic_taken;
        logic c, u, m;
        logic [4:0] ci, wi;
        logic [9:0] d;
        send_one(5'd3, 1'b1, c, ci, u, wi, d, m);
        vec++; if (c !== 1'b1 || ci !== 5'd3) begin errs++; $display("FAIL t1_check got chk=%b cindex=%0d want chk=1 cindex=3", c, ci); end
        vec++; if (u !== 1'b1 || wi !== 5'd3) begin errs++; $display("FAIL t1_upd got upd=%b windex=%0d want upd=1 windex=3", u, wi); end
        vec++; if (d !== 10'b11_00_00_00_01) begin errs++; $display("FAIL t1_data got %b want 1100000001", d); end
        vec++; if (m !== 1'b1) begin errs++; $display("FAIL t1_mispredict got %b want 1", m); end
        @(negedge clk);
        vec++; if (mispredict !== 1'b0 || upd !== 1'b0) begin errs++; $display("FAIL t1_pulse got mp=%b upd=%b want 0 0", mispredict, upd); end
        vec++; if (mispredict_count !== 32'd1) begin errs++; $display("FAIL t1_count got %0d want 1", mispredict_count); end
        vec++; if (idle !== 1'b1) begin errs++; $display("FAIL t1_idle got %b want 1", idle); end
    endtask

    task automatic test_not_taken;
        logic c, u, m;
        logic [4:0] ci, wi;
        logic [9:0] d;
        preload(5'd5, 10'b01_00_11_00_00);
        pf_en  = 1'b1;
        pf_val = 1'b0;
        send_one(5'd5, 1'b0, c, ci, u, wi, d, m);
        pf_en  = 1'b0;
        vec++; if (u !== 1'b1 || wi !== 5'd5) begin errs++; $display("FAIL t2_upd got upd=%b windex=%0d want 1 5", u, wi); end
        vec++; if (d !== 10'b10_00_10_00_00) begin errs++; $display("FAIL t2_data got %b want 1000100000", d); end
        vec++; if (m !== 1'b0) begin errs++; $display("FAIL t2_mispredict got %b want 0", m); end
        @(negedge clk);
        vec++; if (mispredict_count !== 32'd1) begin errs++; $display("FAIL t2_count got %0d want 1", mispredict_count); end
    endtask

    task automatic test_saturation;
        logic c, u, m;
        logic [4:0] ci, wi;
        logic [9:0] d;
        preload(5'd9, 10'b00_11_00_00_00);
        send_one(5'd9, 1'b1, c, ci, u, wi, d, m);
        vec++; if (d !== 10'b01_11_00_00_00 || m !== 1'b0) begin errs++; $display("FAIL sat_st got data=%b mp=%b want 0111000000 0", d, m); end
        preload(5'd10, 10'b10_00_00_00_00);
        send_one(5'd10, 1'b0, c, ci, u, wi, d, m);
        vec++; if (d !== 10'b00_00_00_00_00 || m !== 1'b0) begin errs++; $display("FAIL sat_snt got data=%b mp=%b want 0000000000 0", d, m); end
        vec++; if (wi !== 5'd10) begin errs++; $display("FAIL sat_windex got %0d want 10", wi); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_d [4];
        logic [3:0] exp_mp;
        exp_d[0] = 10'h301;
        exp_d[1] = 10'h302;
        exp_d[2] = 10'h303;
        exp_d[3] = 10'h303;
        exp_mp   = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                vec++;
                if (upd !== 1'b1 || windex !== 5'd7 || datain_update !== exp_d[i-2] || mispredict !== exp_mp[i-2]) begin
                    errs++;
                    $display("FAIL b2b_item%0d got upd=%b windex=%0d data=%h mp=%b want 1 7 %h %b",
                             i-2, upd, windex, datain_update, mispredict, exp_d[i-2], exp_mp[i-2]);
                end
            end
            res_valid = (i < 4);
            res_index = 5'd7;
            res_taken = 1'b1;
        end
        @(negedge clk);
        vec++; if (mispredict_count !== 32'd3) begin errs++; $display("FAIL b2b_count got %0d want 3", mispredict_count); end
    endtask

    task automatic test_stream;
        logic [9:0] exp_d;
        logic       tk;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                tk    = ((i - 2) % 2 == 0);
                exp_d = tk ? 10'h301 : 10'h200;
                vec++;
                if (upd !== 1'b1 || windex !== 5'(12 + i - 2) || datain_update !== exp_d) begin
                    errs++;
                    $display("FAIL stream_item%0d got upd=%b windex=%0d data=%h want 1 %0d %h",
                             i-2, upd, windex, datain_update, 12 + i - 2, exp_d);
                end
            end
            if (i < DEPTH + 2) begin
                vec++;
                if (res_ready !== 1'b1) begin errs++; $display("FAIL stream_ready%0d got %b want 1", i, res_ready); end
            end
            res_valid = (i < DEPTH + 2);
            res_index = 5'(12 + i);
            res_taken = (i % 2 == 0);
        end
        @(negedge clk);
        vec++; if (upd !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL stream_drain got upd=%b idle=%b want 0 1", upd, idle); end
        vec++; if (mispredict_count !== 32'd6) begin errs++; $display("FAIL stream_count got %0d want 6", mispredict_count); end
    endtask

    task automatic test_reset_mid;
        int stray;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            res_valid = 1'b1;
            res_index = 5'(20 + i);
            res_taken = 1'b1;
        end
        @(negedge clk);
        res_valid = 1'b0;
        vec++; if (idle !== 1'b0) begin errs++; $display("FAIL rmid_busy got idle=%b want 0", idle); end
        rst = 1'b1;
        @(negedge clk);
        vec++; if (upd !== 1'b0 || chk !== 1'b0) begin errs++; $display("FAIL rmid_flush got upd=%b chk=%b want 0 0", upd, chk); end
        vec++; if (idle !== 1'b1) begin errs++; $display("FAIL rmid_idle got %b want 1", idle); end
        vec++; if (mispredict_count !== 32'd0) begin errs++; $display("FAIL rmid_count got %0d want 0", mispredict_count); end
        vec++; if (res_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b want 1", res_ready); end
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (upd !== 1'b0 || chk !== 1'b0) stray++;
        end
        vec++; if (stray != 0) begin errs++; $display("FAIL rmid_no_upd got %0d active cycles want 0", stray); end
    endtask

    initial begin
        vec       = 0;
        errs      = 0;
        rst       = 1'b1;
        res_valid = 1'b0;
        res_index = '0;
        res_taken = 1'b0;
        pl_en     = 1'b0;
        pl_idx    = '0;
        pl_val    = '0;
        pf_en     = 1'b0;
        pf_val    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_basic_taken;
        test_not_taken;
        test_saturation;
        test_back_to_back;
        test_stream;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
